// File: rtl/memory_bus_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module  : memory_bus_arbiter_pkg
// Brief   : Shared types and the store lane-steering helper for the arbiter.
// Revision: 1.0 - initial release
// ============================================================================
package memory_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    BYTE = 2'b00,
    HALF = 2'b01,
    WORD = 2'b10,
    RSVD = 2'b11
  } store_width_t;

  typedef enum logic [1:0] {
    IDLE       = 2'b00,
    LOAD_WAIT  = 2'b01,
    STORE_WAIT = 2'b10
  } arb_state_t;

  typedef struct packed {
    logic [3:0]  byte_en;
    logic [31:0] wdata;
    logic        misaligned;
  } store_lanes_t;

  // Reserved width is reported as misaligned so callers need a single error test.
  function automatic store_lanes_t store_lanes(input logic [1:0]  addr,
                                               input store_width_t width,
                                               input logic [31:0] data);
    store_lanes_t r;
    r.byte_en    = 4'b0000;
    r.wdata      = 32'h0;
    r.misaligned = 1'b0;
    case (width)
      BYTE: begin
        r.byte_en = 4'b0001 << addr;
        r.wdata   = {4{data[7:0]}};
      end
      HALF: begin
        r.byte_en    = 4'b0011 << {addr[1], 1'b0};
        r.wdata      = {2{data[15:0]}};
        r.misaligned = addr[0];
      end
      WORD: begin
        r.byte_en    = 4'b1111;
        r.wdata      = data;
        r.misaligned = |addr;
      end
      default: r.misaligned = 1'b1;
    endcase
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/memory_bus_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module  : memory_bus_arbiter_if
// Brief   : Load/store channels and external memory bus seen by the arbiter.
// Revision: 1.0 - initial release
// ============================================================================
interface memory_bus_arbiter_if;
  import memory_bus_arbiter_pkg::*;

  logic         flush_i;
  logic         ld_request_i;
  logic [31:0]  ld_address_i;
  logic         ld_ready_o;
  logic [31:0]  ld_data_o;
  logic         ld_valid_o;
  logic         ld_error_o;
  logic         st_request_i;
  logic [31:0]  st_address_i;
  logic [31:0]  st_data_i;
  store_width_t st_width_i;
  logic         st_ready_o;
  logic         st_done_o;
  logic         st_error_o;
  logic         bus_request_o;
  logic         bus_write_o;
  logic [31:0]  bus_address_o;
  logic [31:0]  bus_wdata_o;
  logic [3:0]   bus_byte_en_o;
  logic         bus_ack_i;
  logic [31:0]  bus_rdata_i;
  logic         bus_error_i;

  modport master (
    input  flush_i, ld_request_i, ld_address_i,
    input  st_request_i, st_address_i, st_data_i, st_width_i,
    input  bus_ack_i, bus_rdata_i, bus_error_i,
    output ld_ready_o, ld_data_o, ld_valid_o, ld_error_o,
    output st_ready_o, st_done_o, st_error_o,
    output bus_request_o, bus_write_o, bus_address_o, bus_wdata_o, bus_byte_en_o
  );

  modport slave (
    output flush_i, ld_request_i, ld_address_i,
    output st_request_i, st_address_i, st_data_i, st_width_i,
    output bus_ack_i, bus_rdata_i, bus_error_i,
    input  ld_ready_o, ld_data_o, ld_valid_o, ld_error_o,
    input  st_ready_o, st_done_o, st_error_o,
    input  bus_request_o, bus_write_o, bus_address_o, bus_wdata_o, bus_byte_en_o
  );

endinterface
`default_nettype wire

// File: rtl/memory_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : memory_bus_arbiter
// Brief   : Load-priority arbiter merging load/store channels onto one bus.
// Revision: 1.0 - initial release
// ============================================================================
module memory_bus_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned STARVE_LIMIT   = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  memory_bus_arbiter_if.master bus_if
);
  import memory_bus_arbiter_pkg::*;

  localparam int unsigned WAIT_W   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int unsigned STARVE_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [WAIT_W-1:0]   WAIT_LAST  = WAIT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

  arb_state_t          state_q;
  logic                ld_pend_q, st_pend_q, st_owe_q, discard_q;
  logic [31:0]         ld_addr_q, st_addr_q, st_wdata_q;
  logic [3:0]          st_be_q;
  logic [STARVE_W-1:0] starve_q;
  logic [WAIT_W-1:0]   wait_q;
  logic                bus_req_q, bus_we_q;
  logic [31:0]         bus_addr_q, bus_wdata_q;
  logic [3:0]          bus_be_q;
  logic                ld_cmpl_q, ld_cmpl_err_q, st_cmpl_q, st_cmpl_err_q;
  logic [31:0]         ld_cmpl_data_q, ld_data_q;
  logic                ld_valid_q, ld_error_q, st_done_q, st_error_q;

  store_lanes_t st_lanes;
  logic         ld_accept, st_accept, st_good, st_bad, ld_live;
  logic         grant_ld, grant_st, bus_done, timeout, finish, fin_err;

  assign st_lanes  = store_lanes(bus_if.st_address_i[1:0], bus_if.st_width_i, bus_if.st_data_i);
  assign ld_accept = bus_if.ld_request_i & ~ld_pend_q & ~bus_if.flush_i;
  assign st_accept = bus_if.st_request_i & ~st_pend_q & ~st_owe_q;
  assign st_good   = st_accept & ~st_lanes.misaligned;
  assign st_bad    = st_accept &  st_lanes.misaligned;
  assign ld_live   = ld_pend_q & ~bus_if.flush_i;

  assign grant_ld  = (state_q == IDLE) & ld_live & ~(st_pend_q & (starve_q == STARVE_MAX));
  assign grant_st  = (state_q == IDLE) & st_pend_q & ~grant_ld;

  // bus_req_q is only ever high in a WAIT state, so it qualifies ack and timeout.
  assign bus_done  = bus_req_q & bus_if.bus_ack_i;
  assign timeout   = bus_req_q & ~bus_if.bus_ack_i & (wait_q == WAIT_LAST);
  assign finish    = bus_done | timeout;
  assign fin_err   = timeout | bus_if.bus_error_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q        <= IDLE;
      ld_pend_q      <= 1'b0;
      st_pend_q      <= 1'b0;
      st_owe_q       <= 1'b0;
      discard_q      <= 1'b0;
      ld_addr_q      <= 32'h0;
      st_addr_q      <= 32'h0;
      st_wdata_q     <= 32'h0;
      st_be_q        <= 4'h0;
      starve_q       <= '0;
      wait_q         <= '0;
      bus_req_q      <= 1'b0;
      bus_we_q       <= 1'b0;
      bus_addr_q     <= 32'h0;
      bus_wdata_q    <= 32'h0;
      bus_be_q       <= 4'h0;
      ld_cmpl_q      <= 1'b0;
      ld_cmpl_err_q  <= 1'b0;
      ld_cmpl_data_q <= 32'h0;
      st_cmpl_q      <= 1'b0;
      st_cmpl_err_q  <= 1'b0;
      ld_data_q      <= 32'h0;
      ld_valid_q     <= 1'b0;
      ld_error_q     <= 1'b0;
      st_done_q      <= 1'b0;
      st_error_q     <= 1'b0;
    end else begin
      ld_cmpl_q  <= 1'b0;
      st_cmpl_q  <= 1'b0;
      ld_valid_q <= 1'b0;
      ld_error_q <= 1'b0;
      st_done_q  <= 1'b0;
      st_error_q <= 1'b0;

      if (ld_accept) begin
        ld_pend_q <= 1'b1;
        ld_addr_q <= bus_if.ld_address_i;
      end else if (bus_if.flush_i || grant_ld) begin
        ld_pend_q <= 1'b0;
      end

      if (st_good) begin
        st_pend_q  <= 1'b1;
        st_addr_q  <= bus_if.st_address_i;
        st_be_q    <= st_lanes.byte_en;
        st_wdata_q <= st_lanes.wdata;
      end else if (grant_st) begin
        st_pend_q <= 1'b0;
      end

      if (ld_cmpl_q) begin
        ld_valid_q <= 1'b1;
        ld_error_q <= ld_cmpl_err_q;
        ld_data_q  <= ld_cmpl_data_q;
      end

      // A rejected store colliding with a bus store completion is reported one
      // cycle later; the owed report keeps the store slot busy meanwhile.
      if (st_cmpl_q) begin
        st_done_q  <= 1'b1;
        st_error_q <= st_cmpl_err_q;
        st_owe_q   <= st_bad;
      end else if (st_bad || st_owe_q) begin
        st_done_q  <= 1'b1;
        st_error_q <= 1'b1;
        st_owe_q   <= 1'b0;
      end

      case (state_q)
        IDLE: begin
          wait_q <= '0;
          if (grant_ld) begin
            state_q     <= LOAD_WAIT;
            bus_req_q   <= 1'b1;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= {ld_addr_q[31:2], 2'b00};
            bus_wdata_q <= 32'h0;
            bus_be_q    <= 4'b1111;
            if (st_pend_q && (starve_q != STARVE_MAX)) begin
              starve_q <= starve_q + 1'b1;
            end
          end else if (grant_st) begin
            state_q     <= STORE_WAIT;
            bus_req_q   <= 1'b1;
            bus_we_q    <= 1'b1;
            bus_addr_q  <= {st_addr_q[31:2], 2'b00};
            bus_wdata_q <= st_wdata_q;
            bus_be_q    <= st_be_q;
            starve_q    <= '0;
          end
        end
        LOAD_WAIT: begin
          if (bus_if.flush_i) begin
            discard_q <= 1'b1;
          end
          if (finish) begin
            state_q   <= IDLE;
            bus_req_q <= 1'b0;
            discard_q <= 1'b0;
            if (!(discard_q || bus_if.flush_i)) begin
              ld_cmpl_q     <= 1'b1;
              ld_cmpl_err_q <= fin_err;
              if (bus_done) begin
                ld_cmpl_data_q <= bus_if.bus_rdata_i;
              end
            end
          end else begin
            wait_q <= wait_q + 1'b1;
          end
        end
        STORE_WAIT: begin
          if (finish) begin
            state_q       <= IDLE;
            bus_req_q     <= 1'b0;
            st_cmpl_q     <= 1'b1;
            st_cmpl_err_q <= fin_err;
          end else begin
            wait_q <= wait_q + 1'b1;
          end
        end
        default: begin
          state_q   <= IDLE;
          bus_req_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus_if.ld_ready_o    = ~ld_pend_q;
  assign bus_if.st_ready_o    = ~(st_pend_q | st_owe_q);
  assign bus_if.ld_data_o     = ld_data_q;
  assign bus_if.ld_valid_o    = ld_valid_q;
  assign bus_if.ld_error_o    = ld_error_q;
  assign bus_if.st_done_o     = st_done_q;
  assign bus_if.st_error_o    = st_error_q;
  assign bus_if.bus_request_o = bus_req_q;
  assign bus_if.bus_write_o   = bus_we_q;
  assign bus_if.bus_address_o = bus_addr_q;
  assign bus_if.bus_wdata_o   = bus_wdata_q;
  assign bus_if.bus_byte_en_o = bus_be_q;

  a_ld_req_ready: assert property (@(posedge clk_i) disable iff (rst_i)
                                   bus_if.ld_request_i |-> !ld_pend_q);
  a_st_req_ready: assert property (@(posedge clk_i) disable iff (rst_i)
                                   bus_if.st_request_i |-> !(st_pend_q || st_owe_q));

endmodule
`default_nettype wire
